// File: rtl/branch_resolution_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolution_unit_pkg
// Shared definitions for the EX-stage branch resolution unit and its update
// FIFO: default widths, FIFO depth, and the packed layout of one predictor
// training entry.
//
// Entry layout (MSB .. LSB):  { pc, target, taken, bhsr }
//   bhsr   : [hist_w-1 : 0]
//   taken  : [hist_w]
//   target : [hist_w+pc_w : hist_w+1]
//   pc     : [hist_w+2*pc_w : hist_w+pc_w+1]
// -----------------------------------------------------------------------------
package branch_resolution_unit_pkg;

   localparam int DEF_PC_WIDTH   = 32;
   localparam int DEF_HIST_WIDTH = 5;
   localparam int DEF_CNT_WIDTH  = 32;

   // Two slots are enough to absorb back-to-back resolves while the predictor
   // finds a free write slot between fetch-side reads.
   localparam int FIFO_DEPTH = 2;

   function automatic int upd_entry_width(input int pc_w, input int hist_w);
      return 2 * pc_w + 1 + hist_w;
   endfunction

   function automatic int upd_taken_lsb(input int hist_w);
      return hist_w;
   endfunction

   function automatic int upd_target_lsb(input int hist_w);
      return hist_w + 1;
   endfunction

   function automatic int upd_pc_lsb(input int pc_w, input int hist_w);
      return hist_w + 1 + pc_w;
   endfunction

endpackage

// File: rtl/branch_resolution_unit_update_fifo.sv
// -----------------------------------------------------------------------------
// update_fifo
// Two-entry synchronous FIFO holding predictor training updates.
// The head entry is presented combinationally on rd_data; it is only
// meaningful while empty is low.
//
// Ports
//   clk      in   clock
//   reset    in   asynchronous, active-low; empties the FIFO
//   wr_en    in   push wr_data (ignored while full)
//   wr_data  in   entry to push
//   rd_en    in   pop the head (ignored while empty)
//   rd_data  out  head entry
//   full     out  both slots occupied
//   empty    out  no slot occupied
//   count    out  occupancy, 0..2
// -----------------------------------------------------------------------------
module update_fifo
   import branch_resolution_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [1:0]            count
);

   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;
   logic [1:0] count_next;
   logic       do_wr;
   logic       do_rd;

   assign full  = (count_reg == 2'(FIFO_DEPTH));
   assign empty = (count_reg == 2'd0);
   assign count = count_reg;

   // A push into a full FIFO is refused even if a pop happens the same cycle.
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   always_comb begin
      count_next = count_reg;
      case ({do_wr, do_rd})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_wr) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_rd) rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_next;
      end
   end

   // Storage slots carry no reset: occupancy alone decides what is valid.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gen_slot
      localparam logic SLOT = 1'(gi);
      logic [DATA_WIDTH-1:0] slot_reg;

      always_ff @(posedge clk) begin
         if (do_wr && (wr_ptr_reg == SLOT)) slot_reg <= wr_data;
      end
   end

   assign rd_data = rd_ptr_reg ? gen_slot[1].slot_reg : gen_slot[0].slot_reg;

endmodule

// File: rtl/branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// branch_resolution_unit
// Resolves control flow in EX against the next-PC chosen by the fetch-side
// gshare predictor. On a mismatch it redirects fetch, flushes IF/ID and ID/EX
// and (for control instructions) repairs the global history. Every resolved
// control instruction is queued as a training update for the predictor.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   ex_valid .. ex_alu_result  EX instruction: pc, predicted next-pc, history
//                              snapshot, control decode, branch condition,
//                              PC+imm and JALR raw target
//   pc_redirect, redirect_pc   fetch must load redirect_pc
//   flush_if_id, flush_id_ex   squash younger stages
//   stall_req                  hold EX and younger while update queue is full
//   hist_restore_valid/value   overwrite global history with repaired value
//   upd_valid/ready, upd_*     training update stream (head of queue)
//   branch_count, mispred_count  statistics, wrap on overflow
// -----------------------------------------------------------------------------
module branch_resolution_unit
   import branch_resolution_unit_pkg::*;
#(
   parameter int PC_WIDTH   = DEF_PC_WIDTH,
   parameter int HIST_WIDTH = DEF_HIST_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   input  logic [PC_WIDTH-1:0]   ex_pc,
   input  logic [PC_WIDTH-1:0]   ex_pred_pc,
   input  logic [HIST_WIDTH-1:0] ex_bhsr,
   input  logic                  ex_is_branch,
   input  logic                  ex_is_jal,
   input  logic                  ex_is_jalr,
   input  logic                  ex_bcond,
   input  logic [PC_WIDTH-1:0]   ex_pc_imm,
   input  logic [PC_WIDTH-1:0]   ex_alu_result,
   output logic                  pc_redirect,
   output logic [PC_WIDTH-1:0]   redirect_pc,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  stall_req,
   output logic                  hist_restore_valid,
   output logic [HIST_WIDTH-1:0] hist_restore_value,
   output logic                  upd_valid,
   input  logic                  upd_ready,
   output logic [PC_WIDTH-1:0]   upd_pc,
   output logic [PC_WIDTH-1:0]   upd_target,
   output logic                  upd_taken,
   output logic [HIST_WIDTH-1:0] upd_bhsr,
   output logic [CNT_WIDTH-1:0]  branch_count,
   output logic [CNT_WIDTH-1:0]  mispred_count
);

   localparam int ENTRY_WIDTH = upd_entry_width(PC_WIDTH, HIST_WIDTH);
   localparam int TAKEN_LSB   = upd_taken_lsb(HIST_WIDTH);
   localparam int TARGET_LSB  = upd_target_lsb(HIST_WIDTH);
   localparam int PC_LSB      = upd_pc_lsb(PC_WIDTH, HIST_WIDTH);

   logic                   is_ctrl;
   logic                   taken;
   logic [PC_WIDTH-1:0]    jalr_target;
   logic [PC_WIDTH-1:0]    actual_next;
   logic [PC_WIDTH-1:0]    train_target;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [1:0]             fifo_count;
   logic                   live;
   logic                   mispredict;
   logic                   enq;
   logic                   deq;
   logic [ENTRY_WIDTH-1:0] enq_entry;
   logic [ENTRY_WIDTH-1:0] head_entry;
   logic [CNT_WIDTH-1:0]   branch_count_reg;
   logic [CNT_WIDTH-1:0]   mispred_count_reg;

   // ---------------- outcome ----------------
   assign is_ctrl     = ex_is_branch | ex_is_jal | ex_is_jalr;
   assign taken       = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_bcond);
   assign jalr_target = {ex_alu_result[PC_WIDTH-1:1], 1'b0};
   assign actual_next = ex_is_jalr ? jalr_target :
                        taken      ? ex_pc_imm   :
                                     ex_pc + PC_WIDTH'(4);

   // Not-taken entries still train the BTB with the branch's own target.
   assign train_target = taken ? actual_next : ex_pc_imm;

   // ---------------- compare / control ----------------
   // Every combinational output is forced low while reset is asserted.
   assign stall_req  = reset & ex_valid & is_ctrl & fifo_full;
   assign live       = reset & ex_valid & ~stall_req;
   // Non-control instructions are compared too: a BTB alias can steer fetch
   // away from pc+4 for an ordinary ALU op. A stalled instruction is not live,
   // so its mispredict fires only in the cycle it finally resolves.
   assign mispredict = live & (ex_pred_pc != actual_next);

   assign pc_redirect = mispredict;
   assign flush_if_id = mispredict;
   assign flush_id_ex = mispredict;
   assign redirect_pc = mispredict ? actual_next : '0;

   // History repair: the fetch-time snapshot shifted by the real direction.
   assign hist_restore_valid = mispredict & is_ctrl;
   assign hist_restore_value = hist_restore_valid ?
                               {ex_bhsr[HIST_WIDTH-2:0], taken} : '0;

   // ---------------- training queue ----------------
   assign enq       = live & is_ctrl;
   assign deq       = upd_ready & ~fifo_empty;
   assign enq_entry = {ex_pc, train_target, taken, ex_bhsr};

   update_fifo #(
      .DATA_WIDTH (ENTRY_WIDTH)
   ) u_update_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (enq),
      .wr_data (enq_entry),
      .rd_en   (deq),
      .rd_data (head_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Head fields read as zero whenever nothing is queued (including reset).
   assign upd_valid  = (fifo_count != 2'd0);
   assign upd_pc     = upd_valid ? head_entry[PC_LSB +: PC_WIDTH]     : '0;
   assign upd_target = upd_valid ? head_entry[TARGET_LSB +: PC_WIDTH] : '0;
   assign upd_taken  = upd_valid & head_entry[TAKEN_LSB];
   assign upd_bhsr   = upd_valid ? head_entry[0 +: HIST_WIDTH]        : '0;

   // ---------------- statistics ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         branch_count_reg  <= '0;
         mispred_count_reg <= '0;
      end else begin
         if (enq)        branch_count_reg  <= branch_count_reg  + CNT_WIDTH'(1);
         if (mispredict) mispred_count_reg <= mispred_count_reg + CNT_WIDTH'(1);
      end
   end

   assign branch_count  = branch_count_reg;
   assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolution_unit
// Directed scenarios with literal expectations followed by randomized
// stimulus, all compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_branch_resolution_unit;

   logic        clk;
   logic        reset_n;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_pred_pc;
   logic [4:0]  ex_bhsr;
   logic        ex_is_branch;
   logic        ex_is_jal;
   logic        ex_is_jalr;
   logic        ex_bcond;
   logic [31:0] ex_pc_imm;
   logic [31:0] ex_alu_result;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        stall_req;
   logic        hist_restore_valid;
   logic [4:0]  hist_restore_value;
   logic        upd_valid;
   logic        upd_ready;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic [4:0]  upd_bhsr;
   logic [31:0] branch_count;
   logic [31:0] mispred_count;

   branch_resolution_unit #(
      .PC_WIDTH   (32),
      .HIST_WIDTH (5),
      .CNT_WIDTH  (32)
   ) dut (
      .clk                (clk),
      .reset              (reset_n),
      .ex_valid           (ex_valid),
      .ex_pc              (ex_pc),
      .ex_pred_pc         (ex_pred_pc),
      .ex_bhsr            (ex_bhsr),
      .ex_is_branch       (ex_is_branch),
      .ex_is_jal          (ex_is_jal),
      .ex_is_jalr         (ex_is_jalr),
      .ex_bcond           (ex_bcond),
      .ex_pc_imm          (ex_pc_imm),
      .ex_alu_result      (ex_alu_result),
      .pc_redirect        (pc_redirect),
      .redirect_pc        (redirect_pc),
      .flush_if_id        (flush_if_id),
      .flush_id_ex        (flush_id_ex),
      .stall_req          (stall_req),
      .hist_restore_valid (hist_restore_valid),
      .hist_restore_value (hist_restore_value),
      .upd_valid          (upd_valid),
      .upd_ready          (upd_ready),
      .upd_pc             (upd_pc),
      .upd_target         (upd_target),
      .upd_taken          (upd_taken),
      .upd_bhsr           (upd_bhsr),
      .branch_count       (branch_count),
      .mispred_count      (mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
      logic [4:0]  bhsr;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_bc;
   logic [31:0] m_mc;

   function automatic logic [31:0] next_pc_of(input logic [31:0] pc, input logic br,
                                              input logic jal, input logic jalr,
                                              input logic bc, input logic [31:0] imm,
                                              input logic [31:0] alu);
      if (jalr)             return alu & 32'hFFFF_FFFE;
      if (jal || (br && bc)) return imm;
      return pc + 32'd4;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Compare all outputs against the model for the current inputs, then
   // advance the model to the state the next clock edge should produce.
   task automatic model_cycle();
      logic        ctrl, tk, full, stall, live, mis, enq;
      logic [31:0] nxt;
      ent_t        e;
      ctrl  = ex_is_branch | ex_is_jal | ex_is_jalr;
      tk    = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_bcond);
      nxt   = next_pc_of(ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr, ex_bcond,
                         ex_pc_imm, ex_alu_result);
      full  = (mq.size() == 2);
      stall = ex_valid && ctrl && full;
      live  = ex_valid && !stall;
      mis   = live && (ex_pred_pc != nxt);
      enq   = live && ctrl;

      chk("stall_req", stall_req, stall);
      chk("pc_redirect", pc_redirect, mis);
      chk("flush_if_id", flush_if_id, mis);
      chk("flush_id_ex", flush_id_ex, mis);
      if (mis) chk("redirect_pc", redirect_pc, nxt);
      chk("hist_restore_valid", hist_restore_valid, mis && ctrl);
      if (mis && ctrl) chk("hist_restore_value", hist_restore_value, {ex_bhsr[3:0], tk});
      chk("upd_valid", upd_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("upd_pc", upd_pc, mq[0].pc);
         chk("upd_target", upd_target, mq[0].target);
         chk("upd_taken", upd_taken, mq[0].taken);
         chk("upd_bhsr", upd_bhsr, mq[0].bhsr);
      end
      chk("branch_count", branch_count, m_bc);
      chk("mispred_count", mispred_count, m_mc);

      if (mq.size() != 0 && upd_ready) void'(mq.pop_front());
      if (enq) begin
         e.pc     = ex_pc;
         e.target = tk ? nxt : ex_pc_imm;
         e.taken  = tk;
         e.bhsr   = ex_bhsr;
         mq.push_back(e);
         m_bc = m_bc + 32'd1;
      end
      if (mis) m_mc = m_mc + 32'd1;
   endtask

   // kind: 0 none, 1 branch, 2 jal, 3 jalr
   task automatic drive(input logic v, input int kind, input logic [31:0] pc,
                        input logic [31:0] pred, input logic [4:0] bhsr,
                        input logic bc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic rdy);
      ex_valid      = v;
      ex_pc         = pc;
      ex_pred_pc    = pred;
      ex_bhsr       = bhsr;
      ex_is_branch  = (kind == 1);
      ex_is_jal     = (kind == 2);
      ex_is_jalr    = (kind == 3);
      ex_bcond      = bc;
      ex_pc_imm     = imm;
      ex_alu_result = alu;
      upd_ready     = rdy;
   endtask

   // Called at posedge+1: drive, settle, compare at the falling edge.
   task automatic cyc(input logic v, input int kind, input logic [31:0] pc,
                      input logic [31:0] pred, input logic [4:0] bhsr,
                      input logic bc, input logic [31:0] imm,
                      input logic [31:0] alu, input logic rdy);
      drive(v, kind, pc, pred, bhsr, bc, imm, alu, rdy);
      #4;
      model_cycle();
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, 0, 32'h0, 32'h0, 5'h0, 1'b0, 32'h0, 32'h0, rdy);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        r_v, r_bc, r_rdy;
      int          r_kind;
      logic [31:0] r_pc, r_imm, r_alu, r_pred, r_nxt;
      logic [4:0]  r_bhsr;

      mq.delete();
      m_bc = 32'd0;
      m_mc = 32'd0;

      // ---------- reset state (a mispredicting ADD is presented) ----------
      reset_n = 1'b0;
      drive(1'b1, 0, 32'h80, 32'h500, 5'h0, 1'b0, 32'h0, 32'h0, 1'b1);
      #2;
      chk("rst_pc_redirect", pc_redirect, 1'b0);
      chk("rst_upd_valid", upd_valid, 1'b0);
      chk("rst_branch_count", branch_count, 32'd0);
      chk("rst_mispred_count", mispred_count, 32'd0);
      idle(1'b1);
      mq.delete();
      m_bc = 32'd0;
      m_mc = 32'd0;
      #12;
      reset_n = 1'b1;
      tick();

      // ---------- BEQ taken, predicted fall-through ----------
      cyc(1'b1, 1, 32'h100, 32'h104, 5'b01010, 1'b1, 32'h140, 32'h0, 1'b1);
      chk("beq_redirect", pc_redirect, 1'b1);
      chk("beq_redirect_pc", redirect_pc, 32'h140);
      chk("beq_hist_value", hist_restore_value, 5'b10101);
      tick();
      idle(1'b1);
      chk("beq_upd_valid", upd_valid, 1'b1);
      chk("beq_upd_pc", upd_pc, 32'h100);
      chk("beq_upd_target", upd_target, 32'h140);
      chk("beq_upd_taken", upd_taken, 1'b1);
      chk("beq_upd_bhsr", upd_bhsr, 5'b01010);
      chk("beq_mispred_count", mispred_count, 32'd1);
      tick();

      // ---------- BNE not taken, predicted correctly ----------
      cyc(1'b1, 1, 32'h200, 32'h204, 5'b00011, 1'b0, 32'h240, 32'h0, 1'b1);
      chk("bne_redirect", pc_redirect, 1'b0);
      tick();
      idle(1'b1);
      chk("bne_upd_taken", upd_taken, 1'b0);
      chk("bne_upd_target", upd_target, 32'h240);
      chk("bne_branch_count", branch_count, 32'd2);
      chk("bne_mispred_count", mispred_count, 32'd1);
      tick();

      // ---------- JALR target LSB cleared ----------
      cyc(1'b1, 3, 32'h300, 32'h3FE, 5'h1F, 1'b0, 32'h0, 32'h3FF, 1'b1);
      chk("jalr_ok_redirect", pc_redirect, 1'b0);
      tick();
      cyc(1'b1, 3, 32'h304, 32'h400, 5'h07, 1'b0, 32'h0, 32'h3FF, 1'b1);
      chk("jalr_bad_redirect_pc", redirect_pc, 32'h3FE);
      tick();

      // ---------- ADD with aliased prediction ----------
      cyc(1'b1, 0, 32'h80, 32'h500, 5'h15, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("add_redirect_pc", redirect_pc, 32'h84);
      chk("add_hist_valid", hist_restore_valid, 1'b0);
      tick();
      idle(1'b1);
      chk("add_no_enqueue", upd_valid, 1'b0);
      tick();

      // ---------- back-pressure: three branches, upd_ready low ----------
      cyc(1'b1, 1, 32'h1000, 32'h1100, 5'h01, 1'b1, 32'h1100, 32'h0, 1'b0);
      tick();
      cyc(1'b1, 1, 32'h1004, 32'h1008, 5'h02, 1'b0, 32'h1200, 32'h0, 1'b0);
      tick();
      cyc(1'b1, 1, 32'h1008, 32'h100C, 5'h03, 1'b1, 32'h1300, 32'h0, 1'b0);
      chk("stall_full", stall_req, 1'b1);
      chk("stall_no_redirect", pc_redirect, 1'b0);
      tick();
      cyc(1'b1, 1, 32'h1008, 32'h100C, 5'h03, 1'b1, 32'h1300, 32'h0, 1'b1);
      chk("stall_full_with_deq", stall_req, 1'b1);
      tick();
      cyc(1'b1, 1, 32'h1008, 32'h100C, 5'h03, 1'b1, 32'h1300, 32'h0, 1'b0);
      chk("stall_release", stall_req, 1'b0);
      chk("stall_release_redirect", redirect_pc, 32'h1300);
      tick();
      idle(1'b1);
      chk("order_second", upd_pc, 32'h1004);
      tick();
      idle(1'b1);
      chk("order_third", upd_pc, 32'h1008);
      tick();
      idle(1'b1);
      tick();

      // ---------- asynchronous reset while full and stalling ----------
      cyc(1'b1, 1, 32'h2000, 32'h2004, 5'h04, 1'b0, 32'h2080, 32'h0, 1'b0);
      tick();
      cyc(1'b1, 1, 32'h2004, 32'h2008, 5'h05, 1'b0, 32'h2080, 32'h0, 1'b0);
      tick();
      drive(1'b1, 1, 32'h2008, 32'h2100, 5'h06, 1'b1, 32'h2100, 32'h0, 1'b0);
      #1;
      chk("pre_reset_stall", stall_req, 1'b1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_reset_upd_valid", upd_valid, 1'b0);
      chk("mid_reset_upd_pc", upd_pc, 32'h0);
      chk("mid_reset_stall", stall_req, 1'b0);
      chk("mid_reset_redirect", pc_redirect, 1'b0);
      chk("mid_reset_branch_count", branch_count, 32'd0);
      chk("mid_reset_mispred_count", mispred_count, 32'd0);
      mq.delete();
      m_bc = 32'd0;
      m_mc = 32'd0;
      #2;
      reset_n = 1'b1;
      #1;
      model_cycle();
      tick();
      idle(1'b0);
      chk("post_reset_upd_valid", upd_valid, 1'b1);
      chk("post_reset_upd_pc", upd_pc, 32'h2008);
      chk("post_reset_branch_count", branch_count, 32'd1);
      tick();

      // ---------- randomized traffic ----------
      for (int n = 0; n < 3000; n++) begin
         r_v    = ($urandom_range(3) != 0);
         r_kind = ($urandom_range(4) == 4) ? 0 : int'($urandom_range(3));
         if (r_kind == 0 && $urandom_range(1) == 1) r_kind = 1;
         r_pc   = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(7) == 0) r_pc = 32'hFFFF_FFFC;
         r_imm  = r_pc + (($urandom & 32'h0000_0FFE) - 32'h800);
         r_alu  = $urandom;
         r_bc   = $urandom_range(1) == 1;
         r_bhsr = 5'($urandom);
         r_rdy  = ($urandom_range(2) != 0);
         r_nxt  = next_pc_of(r_pc, r_kind == 1, r_kind == 2, r_kind == 3, r_bc, r_imm, r_alu);
         case ($urandom_range(3))
            0:       r_pred = $urandom;
            1:       r_pred = r_pc + 32'd4;
            default: r_pred = r_nxt;
         endcase
         cyc(r_v, r_kind, r_pc, r_pred, r_bhsr, r_bc, r_imm, r_alu, r_rdy);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
